// File: rtl/frame_buf_pkg.sv
// Shared encodings and constants for the multi-buffer frame store.
package frame_buf_pkg;

    localparam int unsigned DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rd_state_t;

endpackage

// File: rtl/frame_buf_mem.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
module frame_buf_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wr_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its word until the next read enable.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_buf_multi.sv
// Multi-buffer fixed-length frame store with in-order readout.
// Optional macro FRAME_BUF_DROP_EN: frames offered while all buffers are full are consumed and counted.
module frame_buf_multi
    import frame_buf_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned ADDR_WIDTH = 3,
    parameter  int unsigned NUM_BUFS   = 2,
    localparam int unsigned BUF_W      = $clog2(NUM_BUFS)
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic [BUF_W:0]        full_cnt,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned CNT_W       = BUF_W + 1;
    localparam int unsigned MEM_AW      = BUF_W + ADDR_WIDTH;
    localparam int unsigned FRAME_WORDS = 2 ** ADDR_WIDTH;
    localparam int unsigned MEM_DEPTH   = NUM_BUFS * FRAME_WORDS;

    function automatic logic [BUF_W-1:0] buf_adv(input logic [BUF_W-1:0] b);
        return (b == BUF_W'(NUM_BUFS - 1)) ? '0 : b + BUF_W'(1);
    endfunction

    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic [BUF_W-1:0]      wr_buf;
    logic [BUF_W-1:0]      rd_buf;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [CNT_W-1:0]      full_cnt_nxt;

    logic wr_fire;
    logic wr_commit;
    logic drop_start;
    logic idle_ready;
    logic mem_we;
    logic rd_release;
    logic rd_start;
    logic rd_next_frame;
    logic rd_step;
    logic mem_re;
    logic [MEM_AW-1:0] mem_raddr;

    assign wr_fire    = wr_valid && wr_ready;
    assign wr_commit  = wr_fire && (wr_state == W_FILL) && (wr_addr == '1);
    assign mem_we     = wr_fire && ((wr_state == W_FILL) || ((wr_state == W_IDLE) && !drop_start));
    assign rd_release = rd_valid && rd_ready && rd_last;

    // Completion and release on the same edge cancel out.
    assign full_cnt_nxt = full_cnt + CNT_W'(wr_commit) - CNT_W'(rd_release);

`ifdef FRAME_BUF_DROP_EN
    logic [DROP_CNT_W-1:0] drop_q;

    assign drop_start = (full_cnt == CNT_W'(NUM_BUFS));
    assign idle_ready = 1'b1;
    assign drop_cnt   = drop_q;

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (wr_fire && (wr_state == W_DROP) && (wr_addr == '1) && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_CNT_W'(1);
        end
    end
`else
    assign drop_start = 1'b0;
    assign idle_ready = (full_cnt_nxt < CNT_W'(NUM_BUFS));
    assign drop_cnt   = '0;
`endif

    // Write FSM; wr_ready is registered from next-cycle occupancy.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_state <= W_IDLE;
            wr_buf   <= '0;
            wr_addr  <= '0;
            full_cnt <= '0;
            wr_ready <= 1'b0;
        end else begin
            full_cnt <= full_cnt_nxt;
            case (wr_state)
                W_IDLE: begin
                    if (wr_fire) begin
                        wr_addr  <= ADDR_WIDTH'(1);
                        wr_state <= drop_start ? W_DROP : W_FILL;
                        wr_ready <= 1'b1;
                    end else begin
                        wr_ready <= idle_ready;
                    end
                end
                W_FILL, W_DROP: begin
                    if (wr_fire) begin
                        if (wr_addr == '1) begin
                            wr_addr  <= '0;
                            wr_state <= W_IDLE;
                            wr_ready <= idle_ready;
                            if (wr_state == W_FILL) begin
                                wr_buf <= buf_adv(wr_buf);
                            end
                        end else begin
                            wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    wr_state <= W_IDLE;
                    wr_addr  <= '0;
                end
            endcase
        end
    end

    assign rd_start      = (rd_state == R_IDLE) && (full_cnt != '0);
    assign rd_next_frame = rd_release && (full_cnt_nxt != '0);
    assign rd_step       = (rd_state == R_READ) && rd_valid && rd_ready && !rd_last;
    assign mem_re        = rd_start || rd_next_frame || rd_step;

    always_comb begin
        mem_raddr = {rd_buf, rd_addr};
        if (rd_next_frame) begin
            mem_raddr = {buf_adv(rd_buf), ADDR_WIDTH'(0)};
        end else if (rd_start) begin
            mem_raddr = {rd_buf, ADDR_WIDTH'(0)};
        end
    end

    // Read FSM; rd_addr is the next word to fetch into the output register.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            rd_state <= R_IDLE;
            rd_buf   <= '0;
            rd_addr  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (rd_start) begin
                        rd_state <= R_READ;
                        rd_valid <= 1'b1;
                        rd_last  <= 1'b0;
                        rd_addr  <= ADDR_WIDTH'(1);
                    end
                end
                R_READ: begin
                    if (rd_valid && rd_ready) begin
                        if (rd_last) begin
                            rd_buf <= buf_adv(rd_buf);
                            if (rd_next_frame) begin
                                rd_valid <= 1'b1;
                                rd_last  <= 1'b0;
                                rd_addr  <= ADDR_WIDTH'(1);
                            end else begin
                                rd_state <= R_IDLE;
                                rd_valid <= 1'b0;
                                rd_last  <= 1'b0;
                                rd_addr  <= '0;
                            end
                        end else begin
                            rd_last <= (rd_addr == '1);
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end
            endcase
        end
    end

    frame_buf_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (MEM_AW),
        .DEPTH      (MEM_DEPTH)
    ) u_mem (
        .wr_clk (wr_clk),
        .reset  (reset),
        .we     (mem_we),
        .waddr  ({wr_buf, wr_addr}),
        .wdata  (wr_data),
        .re     (mem_re),
        .raddr  (mem_raddr),
        .rdata  (rd_data)
    );

endmodule

// File: tb/tb_frame_buf_multi.sv
// Directed bench for frame_buf_multi (32-bit words, 8-word frames, 2 buffers).
module tb_frame_buf_multi;

    logic        wr_clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic [1:0]  full_cnt;
    logic [15:0] drop_cnt;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] cap_data[$];
    logic        cap_last[$];
    int          hold_viol;
    int          cap_cycles;
    int          drv_count;

    frame_buf_multi #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (3),
        .NUM_BUFS   (2)
    ) dut (
        .wr_clk   (wr_clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .full_cnt (full_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    // Offer one 8-word frame base..base+7, honouring wr_ready; ends on a falling edge.
    task automatic drive_frame(input logic [31:0] base, input int budget);
        int  t = 0;
        bit  taken;
        drv_count = 0;
        while (drv_count < 8 && t < budget) begin
            wr_valid = 1'b1;
            wr_data  = base + 32'(drv_count);
            taken    = wr_ready;
            @(negedge wr_clk);
            if (taken) drv_count++;
            t++;
        end
        wr_valid = 1'b0;
    endtask

    // Collect n words; toggle alternates rd_ready 1/0 and records hold violations.
    task automatic capture(input int n, input bit toggle, input int budget);
        int          t = 0;
        bit          phase = 1'b1;
        bit          holding = 1'b0;
        logic [31:0] held = '0;
        cap_data.delete();
        cap_last.delete();
        hold_viol = 0;
        while (cap_data.size() < n && t < budget) begin
            if (holding && (rd_valid !== 1'b1 || rd_data !== held)) hold_viol++;
            rd_ready = toggle ? phase : 1'b1;
            holding  = rd_valid && !rd_ready;
            held     = rd_data;
            if (rd_valid && rd_ready) begin
                cap_data.push_back(rd_data);
                cap_last.push_back(rd_last);
            end
            phase = !phase;
            t++;
            @(negedge wr_clk);
        end
        rd_ready   = 1'b0;
        cap_cycles = t;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (2) @(negedge wr_clk);
        vectors++;
        if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: wr_ready=%b rd_valid=%b rd_last=%b, expected 0 0 0", wr_ready, rd_valid, rd_last);
        end
        vectors++;
        if (rd_data !== 32'h0 || full_cnt !== 2'd0 || drop_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_regs: rd_data=%h full_cnt=%0d drop_cnt=%0d, expected 0 0 0", rd_data, full_cnt, drop_cnt);
        end
        reset = 1'b0;
        @(negedge wr_clk);
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_wr_ready: got %b, expected 1", wr_ready);
        end
    endtask

    task automatic test_single_frame();
        rd_ready = 1'b1;
        drive_frame(32'h100, 20);
        vectors++;
        if (drv_count != 8) begin
            miscompares++;
            $display("FAIL sf_write_timeout: accepted %0d words, expected 8", drv_count);
        end
        vectors++;
        if (full_cnt !== 2'd1 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sf_after_commit: full_cnt=%0d rd_valid=%b, expected 1 0", full_cnt, rd_valid);
        end
        @(negedge wr_clk);
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h100) begin
            miscompares++;
            $display("FAIL sf_first_word: rd_valid=%b rd_data=%h, expected 1 00000100", rd_valid, rd_data);
        end
        capture(8, 1'b0, 20);
        vectors++;
        if (cap_data.size() != 8 || cap_cycles != 8) begin
            miscompares++;
            $display("FAIL sf_count: got %0d words in %0d cycles, expected 8 in 8", cap_data.size(), cap_cycles);
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            vectors++;
            if (cap_data[i] !== 32'h100 + 32'(i) || cap_last[i] !== (i == 7)) begin
                miscompares++;
                $display("FAIL sf_word%0d: got %h last=%b, expected %h last=%b", i, cap_data[i], cap_last[i], 32'h100 + 32'(i), (i == 7));
            end
        end
        vectors++;
        if (full_cnt !== 2'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sf_drained: full_cnt=%0d rd_valid=%b, expected 0 0", full_cnt, rd_valid);
        end
    endtask

    task automatic test_two_frames();
        rd_ready = 1'b0;
        drive_frame(32'h200, 20);
        drive_frame(32'h300, 20);
        vectors++;
        if (full_cnt !== 2'd2 || wr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL tf_full: full_cnt=%0d wr_ready=%b, expected 2 0", full_cnt, wr_ready);
        end
        wr_valid = 1'b1;
        wr_data  = 32'h400;
        repeat (3) @(negedge wr_clk);
        vectors++;
        if (wr_ready !== 1'b0 || full_cnt !== 2'd2 || rd_valid !== 1'b1 || rd_data !== 32'h200) begin
            miscompares++;
            $display("FAIL tf_stall: wr_ready=%b full_cnt=%0d rd_valid=%b rd_data=%h, expected 0 2 1 00000200",
                     wr_ready, full_cnt, rd_valid, rd_data);
        end
        fork
            drive_frame(32'h400, 100);
            capture(16, 1'b0, 100);
        join
        vectors++;
        if (cap_data.size() != 16 || cap_cycles != 16 || drv_count != 8) begin
            miscompares++;
            $display("FAIL tf_count: read %0d in %0d cycles, wrote %0d, expected 16 16 8", cap_data.size(), cap_cycles, drv_count);
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            logic [31:0] exp;
            exp = ((i < 8) ? 32'h200 : 32'h300) + 32'(i % 8);
            vectors++;
            if (cap_data[i] !== exp || cap_last[i] !== ((i % 8) == 7)) begin
                miscompares++;
                $display("FAIL tf_word%0d: got %h last=%b, expected %h last=%b", i, cap_data[i], cap_last[i], exp, ((i % 8) == 7));
            end
        end
        vectors++;
        if (full_cnt !== 2'd1 || rd_valid !== 1'b1 || rd_data !== 32'h400) begin
            miscompares++;
            $display("FAIL tf_third_head: full_cnt=%0d rd_valid=%b rd_data=%h, expected 1 1 00000400", full_cnt, rd_valid, rd_data);
        end
        capture(8, 1'b0, 20);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= cap_data.size() || cap_data[i] !== 32'h400 + 32'(i)) begin
                miscompares++;
                $display("FAIL tf_third_word%0d: got %h, expected %h", i, (i < cap_data.size()) ? cap_data[i] : 32'hx, 32'h400 + 32'(i));
            end
        end
        vectors++;
        if (full_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL tf_drained: full_cnt=%0d, expected 0", full_cnt);
        end
    endtask

    task automatic test_same_edge();
        rd_ready = 1'b0;
        drive_frame(32'h500, 20);
        @(negedge wr_clk);
        fork
            drive_frame(32'h600, 20);
            capture(8, 1'b0, 20);
        join
        vectors++;
        if (cap_data.size() != 8 || drv_count != 8) begin
            miscompares++;
            $display("FAIL se_count: read %0d wrote %0d, expected 8 8", cap_data.size(), drv_count);
        end
        vectors++;
        if (full_cnt !== 2'd1) begin
            miscompares++;
            $display("FAIL se_full_cnt: got %0d, expected 1", full_cnt);
        end
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h600 || rd_last !== 1'b0) begin
            miscompares++;
            $display("FAIL se_next_head: rd_valid=%b rd_data=%h rd_last=%b, expected 1 00000600 0", rd_valid, rd_data, rd_last);
        end
        capture(8, 1'b0, 20);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= cap_data.size() || cap_data[i] !== 32'h600 + 32'(i)) begin
                miscompares++;
                $display("FAIL se_word%0d: got %h, expected %h", i, (i < cap_data.size()) ? cap_data[i] : 32'hx, 32'h600 + 32'(i));
            end
        end
        vectors++;
        if (full_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL se_drained: full_cnt=%0d, expected 0", full_cnt);
        end
    endtask

    task automatic test_backpressure();
        rd_ready = 1'b0;
        drive_frame(32'h700, 20);
        capture(8, 1'b1, 40);
        vectors++;
        if (cap_data.size() != 8 || hold_viol != 0) begin
            miscompares++;
            $display("FAIL bp_hold: read %0d words with %0d hold violations, expected 8 and 0", cap_data.size(), hold_viol);
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            vectors++;
            if (cap_data[i] !== 32'h700 + 32'(i) || cap_last[i] !== (i == 7)) begin
                miscompares++;
                $display("FAIL bp_word%0d: got %h last=%b, expected %h last=%b", i, cap_data[i], cap_last[i], 32'h700 + 32'(i), (i == 7));
            end
        end
        vectors++;
        if (full_cnt !== 2'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drained: full_cnt=%0d rd_valid=%b, expected 0 0", full_cnt, rd_valid);
        end
    endtask

    task automatic test_reset_mid();
        rd_ready = 1'b0;
        drive_frame(32'h900, 20);
        capture(2, 1'b0, 10);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h800 + 32'(i);
            @(negedge wr_clk);
        end
        wr_valid = 1'b0;
        reset    = 1'b1;
        @(negedge wr_clk);
        vectors++;
        if (rd_valid !== 1'b0 || full_cnt !== 2'd0 || rd_last !== 1'b0 || rd_data !== 32'h0 || wr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_reset: rd_valid=%b full_cnt=%0d rd_last=%b rd_data=%h wr_ready=%b, expected 0 0 0 0 0",
                     rd_valid, full_cnt, rd_last, rd_data, wr_ready);
        end
        reset = 1'b0;
        @(negedge wr_clk);
        drive_frame(32'hA00, 20);
        capture(8, 1'b0, 20);
        vectors++;
        if (cap_data.size() != 8) begin
            miscompares++;
            $display("FAIL rm_count: read %0d words, expected 8", cap_data.size());
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            vectors++;
            if (cap_data[i] !== 32'hA00 + 32'(i) || cap_last[i] !== (i == 7)) begin
                miscompares++;
                $display("FAIL rm_word%0d: got %h last=%b, expected %h last=%b", i, cap_data[i], cap_last[i], 32'hA00 + 32'(i), (i == 7));
            end
        end
        vectors++;
        if (full_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL rm_drained: full_cnt=%0d, expected 0", full_cnt);
        end
    endtask

`ifdef FRAME_BUF_DROP_EN
    task automatic test_drop();
        rd_ready = 1'b0;
        drive_frame(32'hB00, 20);
        drive_frame(32'hC00, 20);
        vectors++;
        if (full_cnt !== 2'd2 || wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL dr_full: full_cnt=%0d wr_ready=%b, expected 2 1", full_cnt, wr_ready);
        end
        drive_frame(32'hD00, 12);
        vectors++;
        if (drv_count != 8 || drop_cnt !== 16'd1 || full_cnt !== 2'd2) begin
            miscompares++;
            $display("FAIL dr_dropped: wrote %0d drop_cnt=%0d full_cnt=%0d, expected 8 1 2", drv_count, drop_cnt, full_cnt);
        end
        capture(16, 1'b0, 40);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp;
            exp = ((i < 8) ? 32'hB00 : 32'hC00) + 32'(i % 8);
            vectors++;
            if (i >= cap_data.size() || cap_data[i] !== exp) begin
                miscompares++;
                $display("FAIL dr_word%0d: got %h, expected %h", i, (i < cap_data.size()) ? cap_data[i] : 32'hx, exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
`ifndef FRAME_BUF_DROP_EN
        test_two_frames();
`endif
        test_same_edge();
        test_backpressure();
        test_reset_mid();
`ifdef FRAME_BUF_DROP_EN
        test_drop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
